// File: rtl/simon_block_loader_if.sv
// rtl/simon_block_loader_if.sv - byte-stream, core and ciphertext signals of the SIMON block loader
// err exists only when SIMON_LOADER_TIMEOUT_EN is defined.
interface simon_block_loader_if #(
    parameter int BLOCK_W = 96,
    parameter int KEY_W   = 96
);
    logic [7:0]         s_tdata;
    logic               s_tvalid;
    logic               s_tuser;
    logic               s_tready;
    logic               core_en;
    logic [BLOCK_W-1:0] core_plaintext;
    logic [KEY_W-1:0]   core_key;
    logic               core_done;
    logic [BLOCK_W-1:0] core_ciphertext;
    logic [BLOCK_W-1:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               key_valid;
    logic               busy;
`ifdef SIMON_LOADER_TIMEOUT_EN
    logic               err;
`endif

    // Loader side: consumes the byte stream and core result, produces the block.
    modport slave (
`ifdef SIMON_LOADER_TIMEOUT_EN
        output err,
`endif
        input  s_tdata, s_tvalid, s_tuser, core_done, core_ciphertext, m_tready,
        output s_tready, core_en, core_plaintext, core_key, m_tdata, m_tvalid,
        output key_valid, busy
    );

    modport master (
`ifdef SIMON_LOADER_TIMEOUT_EN
        input  err,
`endif
        output s_tdata, s_tvalid, s_tuser, core_done, core_ciphertext, m_tready,
        input  s_tready, core_en, core_plaintext, core_key, m_tdata, m_tvalid,
        input  key_valid, busy
    );
endinterface

// File: rtl/simon_block_loader.sv
// rtl/simon_block_loader.sv - byte-stream feeder and result capture for the SIMON-96/96 core
// Optional run timeout with sticky err: define SIMON_LOADER_TIMEOUT_EN.
module simon_block_loader #(
    parameter int BLOCK_W = 96,
    parameter int KEY_W   = 96
`ifdef SIMON_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 80
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    simon_block_loader_if.slave   bus
);
    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam int KEY_BYTES   = KEY_W / 8;
    localparam int PT_CNT_W    = $clog2(BLOCK_BYTES + 1);
    localparam int KEY_CNT_W   = $clog2(KEY_BYTES + 1);

    typedef enum logic [1:0] {S_FILL, S_START, S_RUN, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [BLOCK_W-1:0]   pt_q, pt_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [PT_CNT_W-1:0]  pt_cnt_q, pt_cnt_d;
    logic [KEY_CNT_W-1:0] key_cnt_q, key_cnt_d;
    logic                 key_valid_q, key_valid_d;
    logic                 core_en_q, core_en_d;
    logic [BLOCK_W-1:0]   m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
`ifdef SIMON_LOADER_TIMEOUT_EN
    localparam int RUN_CNT_W = $clog2(TIMEOUT + 1);
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 err_q, err_d;
`else
    logic                 run_first_q, run_first_d;
`endif

    logic pt_full;
    logic s_tready;
    logic byte_acc;
    logic run_blank;

    assign pt_full  = (pt_cnt_q == PT_CNT_W'(BLOCK_BYTES));
    // Ready is forced low while rst is held so every output reads 0 in reset.
    assign s_tready = !rst && (state_q == S_FILL) && (bus.s_tuser || !pt_full);
    assign byte_acc = bus.s_tvalid && s_tready;

    // The first S_RUN cycle may still see done left over from the previous block.
`ifdef SIMON_LOADER_TIMEOUT_EN
    assign run_blank = (run_cnt_q == '0);
`else
    assign run_blank = run_first_q;
`endif

    always_comb begin
        state_d     = state_q;
        pt_d        = pt_q;
        key_d       = key_q;
        pt_cnt_d    = pt_cnt_q;
        key_cnt_d   = key_cnt_q;
        key_valid_d = key_valid_q;
        core_en_d   = 1'b0;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
`ifdef SIMON_LOADER_TIMEOUT_EN
        run_cnt_d   = run_cnt_q;
        err_d       = err_q;
`else
        run_first_d = run_first_q;
`endif
        case (state_q)
            S_FILL: begin
                if (byte_acc) begin
                    if (bus.s_tuser) begin
                        key_d = {key_q[KEY_W-9:0], bus.s_tdata};
                        if (key_cnt_q == '0) begin
                            key_valid_d = 1'b0;
                        end
                        if (key_cnt_q == KEY_CNT_W'(KEY_BYTES - 1)) begin
                            key_cnt_d   = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            key_cnt_d = key_cnt_q + 1'b1;
                        end
                    end else begin
                        pt_d     = {pt_q[BLOCK_W-9:0], bus.s_tdata};
                        pt_cnt_d = pt_cnt_q + 1'b1;
                    end
                end else if (pt_full && key_valid_q) begin
                    state_d   = S_START;
                    core_en_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_RUN;
`ifdef SIMON_LOADER_TIMEOUT_EN
                run_cnt_d = '0;
`else
                run_first_d = 1'b1;
`endif
            end
            S_RUN: begin
`ifndef SIMON_LOADER_TIMEOUT_EN
                run_first_d = 1'b0;
`endif
                if (!run_blank && bus.core_done) begin
                    m_tdata_d  = bus.core_ciphertext;
                    m_tvalid_d = 1'b1;
                    state_d    = S_OUT;
                end
`ifdef SIMON_LOADER_TIMEOUT_EN
                else if (run_cnt_q == RUN_CNT_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    pt_cnt_d = '0;
                    state_d  = S_FILL;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (bus.m_tready) begin
                    m_tvalid_d = 1'b0;
                    pt_cnt_d   = '0;
                    state_d    = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            pt_q        <= '0;
            key_q       <= '0;
            pt_cnt_q    <= '0;
            key_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            core_en_q   <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
`ifdef SIMON_LOADER_TIMEOUT_EN
            run_cnt_q   <= '0;
            err_q       <= 1'b0;
`else
            run_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            pt_cnt_q    <= pt_cnt_d;
            key_cnt_q   <= key_cnt_d;
            key_valid_q <= key_valid_d;
            core_en_q   <= core_en_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
`ifdef SIMON_LOADER_TIMEOUT_EN
            run_cnt_q   <= run_cnt_d;
            err_q       <= err_d;
`else
            run_first_q <= run_first_d;
`endif
        end
    end

    assign bus.s_tready       = s_tready;
    assign bus.core_en        = core_en_q;
    assign bus.core_plaintext = pt_q;
    assign bus.core_key       = key_q;
    assign bus.m_tdata        = m_tdata_q;
    assign bus.m_tvalid       = m_tvalid_q;
    assign bus.key_valid      = key_valid_q;
    assign bus.busy           = (state_q == S_START) || (state_q == S_RUN);
`ifdef SIMON_LOADER_TIMEOUT_EN
    assign bus.err            = err_q;
`endif
endmodule

// File: tb/tb_simon_block_loader.sv
// tb/tb_simon_block_loader.sv - directed bench for simon_block_loader with a fixed-latency core stub
// Timeout checks are compiled in when SIMON_LOADER_TIMEOUT_EN is defined.
module tb_simon_block_loader;
    localparam int BW      = 96;
    localparam int KW      = 96;
    localparam int TIMEOUT = 80;

    localparam logic [95:0] K1  = 96'h0d0c0b0a0908050403020100;
    localparam logic [95:0] PT1 = 96'h2072616c6c69702065687420;
    localparam logic [95:0] CT1 = 96'h602807a462b469063d8ff082;
    localparam logic [95:0] PT2 = 96'h00112233445566778899aabb;
    localparam logic [95:0] PT3 = 96'hdeadbeef0123456789abcdef;
    localparam logic [95:0] PT4 = 96'hfedcba9876543210a5a55a5a;
    localparam logic [95:0] K2  = 96'h1f2e3d4c5b6a798897a6b5c4;
    localparam logic [95:0] PT5 = 96'h13579bdf2468ace0f0e1d2c3;
    localparam logic [95:0] PT6 = 96'hc0ffee00badf00d012345678;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simon_block_loader_if #(.BLOCK_W(BW), .KEY_W(KW)) bus();
    simon_block_loader #(.BLOCK_W(BW), .KEY_W(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int en_cyc   = 0;
    int mv_cnt   = 0;
    int mv_cyc   = 0;
    int last_acc = 0;
    logic mv_prev  = 1'b0;
    logic stab_err = 1'b0;
    logic stub_dead = 1'b0;
    logic [95:0] snap_pt, snap_key;
    int stub_cnt = 0;

    function automatic logic [95:0] stub_cipher(input logic [95:0] pt, input logic [95:0] key);
        logic [95:0] x;
        if (pt == PT1 && key == K1) return CT1;
        x = pt ^ key;
        return {x[87:0], x[95:88]} ^ 96'h0123456789abcdef01234567;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: enable seen at T+1, stale done dropped from T+2, done and result at T+54.
    always @(posedge clk) begin
        if (rst) begin
            stub_cnt <= 0;
            bus.core_done <= 1'b0;
            bus.core_ciphertext <= '0;
        end else if (bus.core_en) begin
            stub_cnt <= 1;
        end else if (stub_cnt != 0) begin
            if (stub_cnt == 1) bus.core_done <= 1'b0;
            if (stub_cnt == 53) begin
                stub_cnt <= 0;
                if (!stub_dead) begin
                    bus.core_done <= 1'b1;
                    bus.core_ciphertext <= stub_cipher(bus.core_plaintext, bus.core_key);
                end
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.core_en) begin
            en_cnt++;
            en_cyc   = cyc;
            snap_pt  = bus.core_plaintext;
            snap_key = bus.core_key;
        end else if ((bus.busy || bus.m_tvalid) &&
                     (bus.core_plaintext !== snap_pt || bus.core_key !== snap_key)) begin
            stab_err = 1'b1;
        end
        if (bus.m_tvalid && !mv_prev) begin
            mv_cnt++;
            mv_cyc = cyc;
        end
        mv_prev = bus.m_tvalid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic user, input logic [7:0] d);
        int n = 0;
        bus.s_tvalid = 1'b1;
        bus.s_tuser  = user;
        bus.s_tdata  = d;
        #1;
        while (!bus.s_tready && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (!bus.s_tready) check("send_stall", 1'b0, 1'b1);
        last_acc = cyc;
        tick();
        bus.s_tvalid = 1'b0;
    endtask

    task automatic send_field(input logic user, input logic [95:0] v);
        for (int i = 0; i < 12; i++) send_byte(user, v[95-8*i -: 8]);
    endtask

    task automatic wait_mvalid(input string tag);
        int n = 0;
        while (!bus.m_tvalid && n < 300) begin
            tick();
            n++;
        end
        if (!bus.m_tvalid) check({tag, "_mvalid_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (!bus.core_en && n < 300) begin
            tick();
            n++;
        end
        if (!bus.core_en) check({tag, "_en_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        logic [95:0] hold_ct;
        logic bad_hold, bad_rdy, bad_stall;
        rst = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.s_tuser  = 1'b0;
        bus.s_tdata  = 8'h00;
        bus.m_tready = 1'b0;
        repeat (3) tick();

        check("rst_s_tready", bus.s_tready, 1'b0);
        check("rst_key_valid", bus.key_valid, 1'b0);
        check("rst_core_en", bus.core_en, 1'b0);
        check("rst_m_tvalid", bus.m_tvalid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_m_tdata", bus.m_tdata, 96'h0);
        check("rst_core_key", bus.core_key, 96'h0);
        check("rst_core_pt", bus.core_plaintext, 96'h0);
`ifdef SIMON_LOADER_TIMEOUT_EN
        check("rst_err", bus.err, 1'b0);
`endif
        rst = 1'b0;
        tick();
        check("fill_s_tready", bus.s_tready, 1'b1);

        // Block 1: published vector, zero-bubble output
        bus.m_tready = 1'b1;
        send_field(1'b1, K1);
        check("t1_key_valid", bus.key_valid, 1'b1);
        check("t1_core_key", bus.core_key, K1);
        check("t1_idle_busy", bus.busy, 1'b0);
        send_field(1'b0, PT1);
        wait_mvalid("t1");
        check("t1_m_tdata", bus.m_tdata, CT1);
        check("t1_en_to_valid", 32'(mv_cyc - en_cyc), 32'd55);
        check("t1_byte_to_valid", 32'(mv_cyc - last_acc), 32'd57);
        tick();
        check("t1_pulse", bus.m_tvalid, 1'b0);
        check("t1_en_count", 32'(en_cnt), 32'd1);

        // Block 2: plaintext only, key retained, stale done must be blanked
        send_field(1'b0, PT2);
        check("t2_key_valid", bus.key_valid, 1'b1);
        wait_mvalid("t2");
        check("t2_m_tdata", bus.m_tdata, stub_cipher(PT2, K1));
        check("t2_en_to_valid", 32'(mv_cyc - en_cyc), 32'd55);
        tick();
        check("t2_pulse", bus.m_tvalid, 1'b0);
        check("t2_en_count", 32'(en_cnt), 32'd2);

        // Block 3: downstream back-pressure for 20 cycles
        bus.m_tready = 1'b0;
        send_field(1'b0, PT3);
        wait_mvalid("t3");
        hold_ct = bus.m_tdata;
        check("t3_m_tdata", hold_ct, stub_cipher(PT3, K1));
        bus.s_tuser = 1'b1;
        bad_hold = 1'b0;
        bad_rdy  = 1'b0;
        repeat (20) begin
            tick();
            if (bus.m_tdata !== hold_ct || bus.m_tvalid !== 1'b1) bad_hold = 1'b1;
            if (bus.s_tready !== 1'b0) bad_rdy = 1'b1;
        end
        check("t3_hold_stable", bad_hold, 1'b0);
        check("t3_hold_no_ready", bad_rdy, 1'b0);
        bus.m_tready = 1'b1;
        bus.s_tuser  = 1'b0;
        tick();
        check("t3_released", bus.m_tvalid, 1'b0);
        check("t3_pt_cleared", bus.s_tready, 1'b1);
        check("t3_inputs_stable", stab_err, 1'b0);

        // Reset at T+20 of a run
        send_field(1'b0, PT5);
        wait_en("t5");
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("t5_m_tvalid", bus.m_tvalid, 1'b0);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_key_valid", bus.key_valid, 1'b0);
        check("t5_s_tready", bus.s_tready, 1'b0);
        check("t5_core_key", bus.core_key, 96'h0);
        check("t5_core_pt", bus.core_plaintext, 96'h0);
        check("t5_m_tdata", bus.m_tdata, 96'h0);
        check("t5_no_output", 32'(mv_cnt), 32'd3);
        rst = 1'b0;
        tick();

        // Fresh load: 13 plaintext bytes before the key, 13th must stall
        send_field(1'b0, PT4);
        bus.s_tvalid = 1'b1;
        bus.s_tuser  = 1'b0;
        bus.s_tdata  = 8'h99;
        #1;
        bad_stall = bus.s_tready;
        tick();
        tick();
        if (bus.s_tready !== 1'b0 || bus.busy !== 1'b0) bad_stall = 1'b1;
        check("t4_13th_stalled", bad_stall, 1'b0);
        send_field(1'b1, K2);
        wait_mvalid("t4");
        check("t4_core_key", bus.core_key, K2);
        check("t4_core_pt", bus.core_plaintext, PT4);
        check("t4_m_tdata", bus.m_tdata, stub_cipher(PT4, K2));
        check("t4_key_to_valid", 32'(mv_cyc - last_acc), 32'd57);
        check("t4_key_valid", bus.key_valid, 1'b1);
        tick();
        check("t4_inputs_stable", stab_err, 1'b0);

`ifdef SIMON_LOADER_TIMEOUT_EN
        begin
            int n = 0;
            int err_cyc = 0;
            stub_dead = 1'b1;
            send_field(1'b0, PT6);
            wait_en("t6");
            while (!bus.err && n < 300) begin
                tick();
                n++;
            end
            err_cyc = cyc;
            check("t6_err", bus.err, 1'b1);
            check("t6_err_latency", 32'(err_cyc - en_cyc), 32'(TIMEOUT + 1));
            check("t6_no_output", 32'(mv_cnt), 32'd4);
            check("t6_busy", bus.busy, 1'b0);
            check("t6_key_valid", bus.key_valid, 1'b1);
            check("t6_pt_cleared", bus.s_tready, 1'b1);
            repeat (5) tick();
            check("t6_err_sticky", bus.err, 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
